// File: rtl/common_pkg.sv
// Shared NoC types and default widths for the credit relay stage.
package common_pkg;

    localparam int unsigned DEFAULT_VC_W = 2;
    localparam int unsigned DEFAULT_A_W  = 8;
    localparam int unsigned DEFAULT_D_W  = 32;

    typedef struct packed {
        logic [DEFAULT_D_W-1:0] data;
    } payload_t;

    typedef struct packed {
        logic [DEFAULT_A_W-1:0] addr;
    } routeinfo_t;

    // MSB first: {data, last, addr}
    typedef struct packed {
        payload_t   payload;
        logic       last;
        routeinfo_t route;
    } packet_t;

    typedef enum logic [1:0] {
        BFT_HEAD   = 2'd0,
        BFT_BODY   = 2'd1,
        BFT_TAIL   = 2'd2,
        BFT_SINGLE = 2'd3
    } bft_type_e;

endpackage

// File: rtl/noc_vc_fifo.sv
// Per-VC synchronous FIFO. A pop frees its slot before a same-cycle push,
// so push+pop on a full FIFO succeeds; there is no empty-FIFO bypass.
module noc_vc_fifo
    import common_pkg::*;
#(
    parameter int unsigned P_W        = DEFAULT_D_W + 1 + DEFAULT_A_W,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_push,
    input  logic           i_pop,
    input  logic [P_W-1:0] i_data,
    output logic           o_full,
    output logic           o_empty,
    output logic [P_W-1:0] o_head
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [AW:0]    r_wr_ptr;
    logic [AW:0]    r_rd_ptr;
    logic [P_W-1:0] r_mem [FIFO_DEPTH];
    logic           w_do_push;
    logic           w_do_pop;

    // Extra pointer MSB distinguishes full from empty when indices match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; flits are dropped on reset by re-aligning pointers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage write; contents need no reset since empty gates every read.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/noc_credit_modport.sv
// One-hop credit-based relay: per-VC FIFOs, per-VC downstream credit
// counters, round-robin VC arbitration, registered outputs.
module noc_credit_modport
    import common_pkg::*;
#(
    parameter  int unsigned VC_W         = DEFAULT_VC_W,
    parameter  int unsigned A_W          = DEFAULT_A_W,
    parameter  int unsigned D_W          = DEFAULT_D_W,
    parameter  int unsigned FIFO_DEPTH   = 4,
    parameter  int unsigned DOWN_CREDITS = 4,
    localparam int unsigned P_W          = D_W + 1 + A_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [VC_W-1:0] up_vc_target,
    input  logic [P_W-1:0]  up_packet,
    output logic [VC_W-1:0] up_credit_gnt,
    output logic [VC_W-1:0] dn_vc_target,
    output logic [P_W-1:0]  dn_packet,
    input  logic [VC_W-1:0] dn_credit_gnt,
    output logic            overflow_err,
    output logic            credit_err
);

    localparam int unsigned CR_W = $clog2(DOWN_CREDITS + 1);
    localparam int unsigned LG_W = (VC_W > 1) ? $clog2(VC_W) : 1;

    logic [CR_W-1:0] r_credit [VC_W];
    logic [LG_W-1:0] r_last;
    logic [VC_W-1:0] r_dn_vc_target;
    logic [VC_W-1:0] r_up_credit_gnt;
    logic [P_W-1:0]  r_dn_packet;
    logic            r_overflow_err;
    logic            r_credit_err;

    logic [VC_W-1:0] w_full;
    logic [VC_W-1:0] w_empty;
    logic [P_W-1:0]  w_head [VC_W];
    logic [VC_W-1:0] w_eligible;
    logic            w_win_valid;
    logic [LG_W-1:0] w_win_idx;
    logic [LG_W-1:0] w_scan;
    logic [VC_W-1:0] w_grant_oh;
    logic [P_W-1:0]  w_win_packet;
    logic            w_ovf_hit;

    for (genvar v = 0; v < VC_W; v++) begin : g_vc
        noc_vc_fifo #(
            .P_W        (P_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .i_clk   (clk),
            .i_rst_n (rst),
            .i_push  (up_vc_target[v]),
            .i_pop   (w_grant_oh[v]),
            .i_data  (up_packet),
            .o_full  (w_full[v]),
            .o_empty (w_empty[v]),
            .o_head  (w_head[v])
        );

        assign w_eligible[v] = ~w_empty[v] & (r_credit[v] != '0);
    end

    // Round-robin search starting one past the last granted VC, wrapping.
    always_comb begin
        w_win_valid = 1'b0;
        w_win_idx   = '0;
        w_scan      = '0;
        for (int unsigned i = 1; i <= VC_W; i++) begin
            w_scan = LG_W'((32'(r_last) + i) % VC_W);
            if (!w_win_valid && w_eligible[w_scan]) begin
                w_win_valid = 1'b1;
                w_win_idx   = w_scan;
            end
        end
    end

    // Winner one-hot drives both the FIFO pop and the registered outputs.
    always_comb begin
        w_grant_oh = '0;
        if (w_win_valid) w_grant_oh[w_win_idx] = 1'b1;
    end

    assign w_win_packet = w_head[w_win_idx];
    // A write to a full FIFO is lost only if that FIFO is not popped this cycle.
    assign w_ovf_hit    = |(up_vc_target & w_full & ~w_grant_oh);

    // Per-VC credit counters; send and grant together cancel out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned v = 0; v < VC_W; v++) begin
                r_credit[v] <= CR_W'(DOWN_CREDITS);
            end
            r_credit_err <= 1'b0;
        end else begin
            for (int unsigned v = 0; v < VC_W; v++) begin
                case ({w_grant_oh[v], dn_credit_gnt[v]})
                    2'b10: r_credit[v] <= r_credit[v] - {{(CR_W-1){1'b0}}, 1'b1};
                    2'b01: begin
                        if (r_credit[v] == CR_W'(DOWN_CREDITS)) begin
                            r_credit_err <= 1'b1;
                        end else begin
                            r_credit[v] <= r_credit[v] + {{(CR_W-1){1'b0}}, 1'b1};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Registered send outputs, arbitration pointer and sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dn_vc_target  <= '0;
            r_up_credit_gnt <= '0;
            r_dn_packet     <= '0;
            r_last          <= LG_W'(VC_W - 1);
            r_overflow_err  <= 1'b0;
        end else begin
            r_dn_vc_target  <= w_grant_oh;
            r_up_credit_gnt <= w_grant_oh;
            if (w_win_valid) begin
                r_dn_packet <= w_win_packet;
                r_last      <= w_win_idx;
            end
            if (w_ovf_hit) r_overflow_err <= 1'b1;
        end
    end

    assign dn_vc_target  = r_dn_vc_target;
    assign up_credit_gnt = r_up_credit_gnt;
    assign dn_packet     = r_dn_packet;
    assign overflow_err  = r_overflow_err;
    assign credit_err    = r_credit_err;

    // Upstream must target at most one VC per cycle.
    a_target_onehot0 : assert property (@(posedge clk) disable iff (!rst)
        $onehot0(up_vc_target));

endmodule

// File: tb/tb_noc_credit_modport.sv
// Directed + randomized bench for noc_credit_modport against a queue-based
// reference model of the relay stage.
module tb_noc_credit_modport;

    localparam int VC_W  = 2;
    localparam int A_W   = 8;
    localparam int D_W   = 32;
    localparam int DEPTH = 4;
    localparam int DNC   = 4;
    localparam int P_W   = D_W + 1 + A_W;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [VC_W-1:0] up_vc_target = '0;
    logic [P_W-1:0]  up_packet = '0;
    logic [VC_W-1:0] up_credit_gnt;
    logic [VC_W-1:0] dn_vc_target;
    logic [P_W-1:0]  dn_packet;
    logic [VC_W-1:0] dn_credit_gnt = '0;
    logic            overflow_err;
    logic            credit_err;

    noc_credit_modport #(
        .VC_W         (VC_W),
        .A_W          (A_W),
        .D_W          (D_W),
        .FIFO_DEPTH   (DEPTH),
        .DOWN_CREDITS (DNC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .up_vc_target  (up_vc_target),
        .up_packet     (up_packet),
        .up_credit_gnt (up_credit_gnt),
        .dn_vc_target  (dn_vc_target),
        .dn_packet     (dn_packet),
        .dn_credit_gnt (dn_credit_gnt),
        .overflow_err  (overflow_err),
        .credit_err    (credit_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int sent_vc1 = 0;

    // Reference model state
    logic [P_W-1:0]  mq [VC_W][$];
    int              mcred [VC_W];
    int              mlast;
    logic [VC_W-1:0] e_vc;
    logic [VC_W-1:0] e_up;
    logic [P_W-1:0]  e_pkt;
    logic            e_ovf;
    logic            e_cerr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int v = 0; v < VC_W; v++) begin
            mq[v].delete();
            mcred[v] = DNC;
        end
        mlast  = VC_W - 1;
        e_vc   = '0;
        e_up   = '0;
        e_pkt  = '0;
        e_ovf  = 1'b0;
        e_cerr = 1'b0;
    endfunction

    // One clock edge of the relay: send from pre-edge state, then credits, then writes.
    function automatic void model_edge(input logic [VC_W-1:0] tgt, input logic [P_W-1:0] pkt,
                                       input logic [VC_W-1:0] gnt);
        int w;
        w = -1;
        for (int i = 1; i <= VC_W; i++) begin
            int v;
            v = (mlast + i) % VC_W;
            if (w < 0 && mq[v].size() > 0 && mcred[v] > 0) w = v;
        end
        e_vc = '0;
        e_up = '0;
        if (w >= 0) begin
            e_pkt = mq[w].pop_front();
            mcred[w]--;
            e_vc  = VC_W'(1) << w;
            e_up  = VC_W'(1) << w;
            mlast = w;
        end
        for (int v = 0; v < VC_W; v++) begin
            if (gnt[v]) begin
                if (mcred[v] == DNC) e_cerr = 1'b1;
                else mcred[v]++;
            end
        end
        for (int v = 0; v < VC_W; v++) begin
            if (tgt[v]) begin
                if (mq[v].size() < DEPTH) mq[v].push_back(pkt);
                else e_ovf = 1'b1;
            end
        end
    endfunction

    task automatic cycle(input logic [VC_W-1:0] tgt, input logic [P_W-1:0] pkt,
                         input logic [VC_W-1:0] gnt);
        up_vc_target  = tgt;
        up_packet     = pkt;
        dn_credit_gnt = gnt;
        model_edge(tgt, pkt, gnt);
        @(posedge clk);
        #1;
        if (dn_vc_target[1]) sent_vc1++;
        chk("dn_vc_target",  64'(dn_vc_target),  64'(e_vc));
        chk("up_credit_gnt", 64'(up_credit_gnt), 64'(e_up));
        chk("dn_packet",     64'(dn_packet),     64'(e_pkt));
        chk("overflow_err",  64'(overflow_err),  64'(e_ovf));
        chk("credit_err",    64'(credit_err),    64'(e_cerr));
        up_vc_target  = '0;
        dn_credit_gnt = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle('0, '0, '0);
    endtask

    function automatic logic [P_W-1:0] rnd_pkt();
        return P_W'({$urandom, $urandom});
    endfunction

    // Asserts reset between edges, checks outputs clear without a clock edge.
    task automatic hard_reset();
        #2;
        rst = 1'b0;
        #1;
        chk("rst_dn_vc_target",  64'(dn_vc_target),  64'(0));
        chk("rst_up_credit_gnt", 64'(up_credit_gnt), 64'(0));
        chk("rst_dn_packet",     64'(dn_packet),     64'(0));
        chk("rst_overflow_err",  64'(overflow_err),  64'(0));
        chk("rst_credit_err",    64'(credit_err),    64'(0));
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    localparam logic [P_W-1:0] P1 = {32'hDEADBEEF, 1'b1, 8'h12};

    initial begin
        logic [VC_W-1:0] tgt;
        logic [VC_W-1:0] gnt;
        int sel;

        // Power-on reset state
        #3;
        chk("por_dn_vc_target",  64'(dn_vc_target),  64'(0));
        chk("por_up_credit_gnt", 64'(up_credit_gnt), 64'(0));
        chk("por_dn_packet",     64'(dn_packet),     64'(0));
        chk("por_overflow_err",  64'(overflow_err),  64'(0));
        chk("por_credit_err",    64'(credit_err),    64'(0));
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Single flit on VC0, one cycle in the FIFO
        cycle(2'b01, P1, '0);
        chk("single_not_yet", 64'(dn_vc_target), 64'(0));
        cycle('0, '0, '0);
        chk("single_vc",  64'(dn_vc_target),  64'(2'b01));
        chk("single_pkt", 64'(dn_packet),     64'(P1));
        chk("single_gnt", 64'(up_credit_gnt), 64'(2'b01));
        idle(2);

        // Credit exhaustion on VC1
        hard_reset();
        sent_vc1 = 0;
        for (int i = 0; i < 6; i++) cycle(2'b10, rnd_pkt(), '0);
        idle(4);
        chk("vc1_sent_4", 64'(sent_vc1), 64'(4));
        cycle('0, '0, 2'b10);
        cycle('0, '0, '0);
        chk("vc1_after_gnt1", 64'(dn_vc_target), 64'(2'b10));
        chk("vc1_sent_5", 64'(sent_vc1), 64'(5));
        cycle('0, '0, 2'b10);
        cycle('0, '0, '0);
        chk("vc1_sent_6", 64'(sent_vc1), 64'(6));
        idle(3);
        chk("vc1_sent_final", 64'(sent_vc1), 64'(6));

        // Round-robin between VC0 and VC1
        hard_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(2'b01, rnd_pkt(), '0);
            cycle(2'b10, rnd_pkt(), '0);
        end
        idle(4);

        // Full FIFO: drain credits, fill, push+pop on full, then overflow
        hard_reset();
        for (int i = 0; i < 4; i++) cycle(2'b01, rnd_pkt(), '0);
        idle(2);
        for (int i = 0; i < 4; i++) cycle(2'b01, rnd_pkt(), '0);
        idle(2);
        cycle('0, '0, 2'b01);
        cycle(2'b01, rnd_pkt(), '0);
        chk("full_push_pop_no_ovf", 64'(overflow_err), 64'(0));
        cycle(2'b01, rnd_pkt(), '0);
        chk("full_push_ovf", 64'(overflow_err), 64'(1));
        for (int i = 0; i < 4; i++) cycle('0, '0, 2'b01);
        idle(6);

        // Credit return at full count saturates and flags
        hard_reset();
        cycle('0, '0, 2'b01);
        chk("credit_err_set", 64'(credit_err), 64'(1));
        for (int i = 0; i < 6; i++) cycle(2'b01, rnd_pkt(), '0);
        idle(4);

        // Async reset in the middle of traffic drops buffered flits
        hard_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(2'b01, rnd_pkt(), '0);
            cycle(2'b10, rnd_pkt(), '0);
        end
        hard_reset();
        idle(5);

        // Randomized traffic, with a mid-run reset to clear sticky flags
        for (int n = 0; n < 600; n++) begin
            if (n == 300) hard_reset();
            sel = int'($urandom_range(0, VC_W));
            tgt = (sel == 0) ? '0 : (VC_W'(1) << (sel - 1));
            gnt = '0;
            for (int v = 0; v < VC_W; v++) begin
                if ($urandom_range(0, 2) == 0) gnt[v] = 1'b1;
            end
            cycle(tgt, rnd_pkt(), gnt);
        end
        idle(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/noc_credit_modport.md
# noc_credit_modport

One-hop credit-based NoC relay stage with a receiver side facing an upstream transmitter and a transmitter side facing a downstream receiver. Arriving flits are buffered in per-virtual-channel FIFOs and forwarded downstream under per-VC credit control, with round-robin VC arbitration. Each dequeue returns one credit upstream. Used between routers or between a router and a PE bridge to break timing and decouple backpressure.

## Interface
- VC_W, default 2: number of virtual channels, one bit per VC, one-hot encoding.
- A_W, default 8: address (routeinfo) width.
- D_W, default 32: data width.
- FIFO_DEPTH, default 4: entries per VC FIFO, power of two, ≥2. The upstream side starts with this many credits per VC.
- DOWN_CREDITS, default 4: initial credits per VC granted by downstream, ≥1.
- Packet layout, P_W = D_W+1+A_W, MSB first: {data, last, addr}.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- up_vc_target  in  VC_W  one-hot0; bit v set writes up_packet into VC v.
- up_packet  in  P_W  flit from upstream.
- up_credit_gnt  out  VC_W  one-cycle pulse per VC returning one credit upstream.
- dn_vc_target  out  VC_W  one-hot0; flit valid for VC v.
- dn_packet  out  P_W  flit to downstream.
- dn_credit_gnt  in  VC_W  credits returned by downstream; multiple bits may be set in one cycle.
- overflow_err  out  1  sticky; a write targeted a full FIFO.
- credit_err  out  1  sticky; a credit return would exceed DOWN_CREDITS.

## Operation
- Receive path:
  - Each edge with up_vc_target[v]=1 pushes up_packet into FIFO v.
  - If FIFO v is full, the write is discarded and overflow_err is set.
  - A multi-hot up_vc_target is illegal; the design asserts on it in simulation.
- Credit counters:
  - One counter per VC, range 0..DOWN_CREDITS, reset to DOWN_CREDITS.
  - Decremented on a send on that VC; incremented when dn_credit_gnt[v]=1.
  - A simultaneous send and grant on the same VC leaves the counter unchanged.
  - An increment at DOWN_CREDITS saturates and sets credit_err.
- Arbitration:
  - VC v is eligible when FIFO v is non-empty and credit[v]>0.
  - Round-robin among eligible VCs; the search starts at last_granted+1 and wraps.
  - last_granted resets to VC_W-1, so VC0 has first priority after reset.
  - At most one VC wins per cycle; the pointer updates only on a grant.
- Send: for the winner v, FIFO v pops, credit[v] decrements, dn_vc_target/dn_packet are registered with one-hot v and the head flit, and up_credit_gnt[v] is registered high. With no winner, dn_vc_target=0 and up_credit_gnt=0. dn_packet holds its last value when not targeted.
- A push and pop on the same FIFO in the same cycle are both performed, including when the FIFO is full (pop frees the slot first, then the write succeeds) or empty (no bypass; the pop of that flit occurs next cycle).
- The `last` bit is carried transparently. There is no packet locking: flits of different VCs may interleave.

## Timing
- All outputs are registered.
- Reset values:
  - dn_vc_target=0, dn_packet=0, up_credit_gnt=0.
  - overflow_err=0, credit_err=0.
  - All FIFOs empty; credits=DOWN_CREDITS.
- Latency: a flit written at edge E0 can appear on dn_* after edge E1 at the earliest (one cycle in the FIFO). Its matching up_credit_gnt pulse is coincident with dn_vc_target.
- Throughput: one flit per cycle total, across all VCs.
- A credit granted at edge E is usable by the arbitration that loads at edge E+1.
- Reset asserted mid-operation drops all buffered flits and restores reset values immediately.

## Structure
- The shared package common_pkg holds:
  - DEFAULT_VC_W, DEFAULT_A_W, DEFAULT_D_W;
  - the payload/routeinfo/packet packed struct typedefs;
  - bft_type_e.
- Sub-module noc_vc_fifo: a synchronous FIFO (P_W, FIFO_DEPTH) with push/pop/full/empty/head, instantiated VC_W times.
- The arbiter and credit counters live in the top module.

## Test plan
- Single flit: after reset, push addr=0x12, data=0xDEADBEEF, last=1 on VC0 → dn_vc_target=01 with the same packet one cycle later, and up_credit_gnt=01 in the same cycle.
- Credit exhaustion: with DOWN_CREDITS=4 and no dn_credit_gnt, push 6 flits on VC1 → exactly 4 sent. Then pulse dn_credit_gnt=10 twice → the remaining 2 are sent, one cycle after each grant edge.
- Round-robin: preload 3 flits each on VC0 and VC1 with ample credits → dn_vc_target sequence 01,10,01,10,01,10.
- Full FIFO: stall credits, push 5 flits on VC0 with FIFO_DEPTH=4 → overflow_err=1 and the 5th flit is never emitted. A simultaneous push and pop on a full FIFO must not set overflow_err.
- Credit error: with a counter at DOWN_CREDITS, assert dn_credit_gnt for that VC → credit_err=1 and the counter stays at 4.
- Async reset: assert rst low mid-stream, between edges → all outputs drop to 0 immediately, and after release there is no stale flit.
